// File: rtl/cmd_issuer.sv
// cmd_issuer: assembles little-endian host bytes into 32-bit command words,
// queues them in a small FIFO and issues each one to the text area as a
// SETUP / STROBE / HOLD handshake on o_cmd_clk / o_cmd_data.
// Optional build macro: CMD_BLANK_SYNC_EN -- when defined, a new command is
// only launched while i_blank is high (a launched command always completes).
module cmd_issuer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic                            i_byte_valid,
  input  logic [7:0]                      i_byte_data,
  output logic                            o_byte_ready,
  input  logic                            i_resync,
  input  logic                            i_blank,
  output logic                            o_cmd_clk,
  output logic [31:0]                     o_cmd_data,
  output logic [$clog2(FIFO_DEPTH):0]     o_level,
  output logic                            o_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t         state_reg;
  state_t         state_next;
  logic           launch;
  logic           blank_ok;

  logic [1:0]     byte_cnt_reg;
  logic [23:0]    part_word;
  logic           accept;
  logic           push;
  logic           fifo_full;
  logic           fifo_empty;

  logic [31:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW:0]    level_reg;
  logic [31:0]    cmd_data_reg;

`ifdef CMD_BLANK_SYNC_EN
  assign blank_ok = i_blank;
`else
  // Blanking has no effect in this build; the port is kept for pin compatibility.
  logic unused_blank;
  assign unused_blank = i_blank;
  assign blank_ok     = 1'b1;
`endif

  assign fifo_full  = (level_reg == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (level_reg == '0);

  // Byte 3 completes a word, so it may only be taken when the FIFO has room.
  assign o_byte_ready = !i_resync && !((byte_cnt_reg == 2'd3) && fifo_full);
  assign accept       = i_byte_valid && o_byte_ready;
  assign push         = accept && (byte_cnt_reg == 2'd3);

  // Byte lanes 0..2 hold the partial word; lane 3 goes straight into the FIFO.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      logic [7:0] lane_reg;

      // Capture the host byte when the counter points at this lane; resync clears.
      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          lane_reg <= 8'h00;
        end else if (i_resync) begin
          lane_reg <= 8'h00;
        end else if (accept && (byte_cnt_reg == 2'(gi))) begin
          lane_reg <= i_byte_data;
        end
      end

      assign part_word[8*gi +: 8] = lane_reg;
    end
  endgenerate

  // Byte counter: advances per accepted byte and wraps 3->0; resync restarts it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      byte_cnt_reg <= 2'd0;
    end else if (i_resync) begin
      byte_cnt_reg <= 2'd0;
    end else if (accept) begin
      byte_cnt_reg <= byte_cnt_reg + 2'd1;
    end
  end

  // FIFO storage: plain array written on push, no reset so it maps to RAM.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {i_byte_data, part_word};
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leave the level unchanged.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (launch) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, launch})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Issue FSM state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Issue FSM: launch from IDLE when a word is queued, then walk the fixed handshake.
  always_comb begin
    state_next = state_reg;
    launch     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty && blank_ok) begin
          launch     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP:   state_next = STROBE;
      STROBE:  state_next = HOLD;
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command word register: registered read of the FIFO head at launch, held afterwards.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cmd_data_reg <= 32'h0;
    end else if (launch) begin
      cmd_data_reg <= fifo_mem[rd_ptr_reg];
    end
  end

  assign o_cmd_clk  = (state_reg == STROBE);
  assign o_cmd_data = cmd_data_reg;
  assign o_level    = level_reg;
  assign o_busy     = (state_reg != IDLE) || !fifo_empty || (byte_cnt_reg != 2'd0);

endmodule

// File: tb/tb_cmd_issuer.sv
// tb_cmd_issuer: directed and randomized stimulus for cmd_issuer, checked every
// cycle against a queue-based behavioural model of the command path.
`timescale 1ns/1ps
module tb_cmd_issuer;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        i_byte_valid = 1'b0;
  logic [7:0]  i_byte_data = 8'h00;
  logic        o_byte_ready;
  logic        i_resync = 1'b0;
  logic        i_blank = 1'b0;
  logic        o_cmd_clk;
  logic [31:0] o_cmd_data;
  logic [2:0]  o_level;
  logic        o_busy;

  cmd_issuer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .i_byte_valid (i_byte_valid),
    .i_byte_data  (i_byte_data),
    .o_byte_ready (o_byte_ready),
    .i_resync     (i_resync),
    .i_blank      (i_blank),
    .o_cmd_clk    (o_cmd_clk),
    .o_cmd_data   (o_cmd_data),
    .o_level      (o_level),
    .o_busy       (o_busy)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Behavioural model: words waiting, bytes collected, cycles since launch.
  logic [31:0] m_q[$];
  logic [7:0]  m_part[4];
  int          m_cnt   = 0;
  int          m_phase = 0;
  logic [31:0] m_cmd   = 32'h0;
  int          cyc     = 0;
  int          last_strobe = -100;
  int          strobe_cycles[$];
  bit          last_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cnt   = 0;
    m_phase = 0;
    m_cmd   = 32'h0;
    for (int i = 0; i < 4; i++) m_part[i] = 8'h00;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_cmd_clk"}, o_cmd_clk, (m_phase == 2));
    chk({tag, "_cmd_data"}, o_cmd_data, m_cmd);
    chk({tag, "_level"}, o_level, m_q.size());
    chk({tag, "_busy"}, o_busy, (m_phase != 0) || (m_q.size() != 0) || (m_cnt != 0));
  endtask

  // One clock cycle: drive inputs, check ready, clock, advance model, check outputs.
  task automatic step(input bit v, input logic [7:0] d, input bit rs, input bit bl);
    bit exp_rdy;
    bit launch;
    i_byte_valid = v;
    i_byte_data  = d;
    i_resync     = rs;
    i_blank      = bl;
    #1;
    exp_rdy = !rs && !(m_cnt == 3 && m_q.size() == DEPTH);
    chk("byte_ready", o_byte_ready, exp_rdy);
    @(posedge clk_i);
    cyc++;
    launch = (m_phase == 0) && (m_q.size() > 0);
`ifdef CMD_BLANK_SYNC_EN
    launch = launch && bl;
`endif
    last_acc = v && exp_rdy;
    if (launch) begin
      m_cmd   = m_q.pop_front();
      m_phase = 1;
    end else if (m_phase != 0) begin
      m_phase = (m_phase + 1) % 4;
    end
    if (rs) begin
      m_cnt = 0;
      for (int i = 0; i < 4; i++) m_part[i] = 8'h00;
    end else if (last_acc) begin
      m_part[m_cnt] = d;
      if (m_cnt == 3) begin
        m_q.push_back({d, m_part[2], m_part[1], m_part[0]});
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    #1;
    check_outputs("cyc");
    if (o_cmd_clk === 1'b1) begin
      chk("strobe_spacing_ge4", (cyc - last_strobe) >= 4, 1);
      last_strobe = cyc;
      strobe_cycles.push_back(cyc);
    end
    @(negedge clk_i);
  endtask

  task automatic idle(input int n, input bit bl);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, bl);
  endtask

  task automatic do_reset();
    rstn_i       = 1'b0;
    i_byte_valid = 1'b0;
    i_resync     = 1'b0;
    #1;
    model_reset();
    chk("rst_ready", o_byte_ready, 1);
    check_outputs("rst");
    @(posedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;
    last_strobe = -100;
  endtask

  logic [7:0] bytes_a[4];
  logic [7:0] bytes_b[4];
  int idx;
  int guard;
  bit seen;

  initial begin
    bytes_a = '{8'h11, 8'h22, 8'h33, 8'h44};
    bytes_b = '{8'h01, 8'h02, 8'h03, 8'h04};
    @(negedge clk_i);
    do_reset();

    // Back-to-back word: strobe three cycles after the fourth byte.
    for (int i = 0; i < 4; i++) step(1'b1, bytes_a[i], 1'b0, 1'b1);
    idle(2, 1'b1);
    chk("lat_strobe", o_cmd_clk, 1);
    chk("lat_data", o_cmd_data, 32'h44332211);
    idle(2, 1'b1);
    chk("idle_busy", o_busy, 0);
    idle(2, 1'b1);

    // Partial word discarded by resync.
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    step(1'b1, 8'hBB, 1'b0, 1'b1);
    step(1'b1, 8'hCC, 1'b1, 1'b1);
    strobe_cycles.delete();
    for (int i = 0; i < 4; i++) step(1'b1, bytes_b[i], 1'b0, 1'b1);
    idle(2, 1'b1);
    chk("resync_data", o_cmd_data, 32'h04030201);
    idle(6, 1'b1);
    chk("resync_strobes", strobe_cycles.size(), 1);

    // Continuous 24-byte stream: six strobes, exactly four cycles apart.
    strobe_cycles.delete();
    idx = 0;
    guard = 0;
    while (idx < 24 && guard < 200) begin
      step(1'b1, 8'(8'h30 + idx), 1'b0, 1'b1);
      if (last_acc) idx++;
      guard++;
    end
    chk("stream_bytes_taken", idx, 24);
    idle(12, 1'b1);
    chk("stream_strobes", strobe_cycles.size(), 6);
    for (int i = 1; i < strobe_cycles.size(); i++)
      chk("stream_spacing", strobe_cycles[i] - strobe_cycles[i-1], 4);

`ifdef CMD_BLANK_SYNC_EN
    // Blank-gated launch: waits while blank low, completes once started.
    strobe_cycles.delete();
    for (int i = 0; i < 4; i++) step(1'b1, bytes_b[i], 1'b0, 1'b0);
    idle(6, 1'b0);
    chk("blank_hold_level", o_level, 1);
    chk("blank_hold_strobes", strobe_cycles.size(), 0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(1, 1'b0);
    chk("blank_strobe", o_cmd_clk, 1);
    idle(4, 1'b0);
    chk("blank_strobes", strobe_cycles.size(), 1);
    // Fill the FIFO while blank is low to exercise the full back-pressure.
    idx = 0;
    guard = 0;
    while (guard < 40) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0);
      guard++;
    end
    chk("full_level", o_level, DEPTH);
    chk("full_ready", o_byte_ready, 0);
    idle(24, 1'b1);
`endif

    // Reset in the middle of a strobe with words in flight.
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (o_cmd_clk === 1'b1) seen = 1'b1;
      else step(1'b0, 8'h00, 1'b0, 1'b1);
    end
    chk("rst_strobe_seen", seen, 1);
    rstn_i = 1'b0;
    #1;
    chk("rst_mid_cmd_clk", o_cmd_clk, 0);
    chk("rst_mid_cmd_data", o_cmd_data, 32'h0);
    chk("rst_mid_level", o_level, 0);
    do_reset();
    strobe_cycles.delete();
    idle(10, 1'b1);
    chk("rst_no_strobes", strobe_cycles.size(), 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 31) == 0,
           1'($urandom_range(0, 1)));
    idle(30, 1'b1);
    chk("final_level", o_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
